// File: rtl/parameterized_ror_pkg.sv
// Shared constants and helpers for the rotate/shift datapath blocks.
// Holds default widths and the elaboration-time distance reduction.
package ror_pkg;

  localparam int ROR_DEFAULT_N = 16;
  localparam int ROR_DEFAULT_M = 4;

  // Reduce a rotate distance into the range 0..n-1.
  function automatic int ror_mod(input int m, input int n);
    return m % n;
  endfunction

endpackage

// File: rtl/parameterized_ror_if.sv
// Operand/result bundle for the registered rotate unit.
// slave: in_valid, i0 in; result, out_valid out. master: mirror.
interface parameterized_ror_if
  import ror_pkg::*;
#(
  parameter int N = ROR_DEFAULT_N
);

  logic         in_valid;
  logic [N-1:0] i0;
  logic [N-1:0] result;
  logic         out_valid;

  modport master (
    output in_valid,
    output i0,
    input  result,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  i0,
    output result,
    output out_valid
  );

endinterface

// File: rtl/parameterized_ror_core.sv
// Combinational barrel rotate-right of i0 by K (0 <= K < N).
// Ports: i0 operand in, rot rotated word out.
module ror_core #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic [N-1:0] i0,
  output logic [N-1:0] rot
);

  localparam int STAGES = (N > 2) ? $clog2(N) : 1;
  localparam logic [STAGES-1:0] AMT = K[STAGES-1:0];

  logic [N-1:0] st [0:STAGES];

  assign st[0] = i0;

  // Stage j rotates by 2^j when amount bit j is set; the
  // amount is a constant here but the mux keeps it dynamic-ready.
  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    localparam int SH = (1 << j) % N;
    for (genvar i = 0; i < N; i++) begin : g_bit
      assign st[j+1][i] = AMT[j] ? st[j][(i + SH) % N]
                                 : st[j][i];
    end
  end

  assign rot = st[STAGES];

endmodule

// File: rtl/parameterized_ror.sv
// Registered constant-distance rotate-right (distance M mod N).
// Ports: clk, rst (sync, active-high), bus (slave: in_valid/i0 -> result/out_valid).
module parameterized_ror
  import ror_pkg::*;
#(
  parameter int N = ROR_DEFAULT_N,
  parameter int M = ROR_DEFAULT_M
) (
  input  logic                 clk,
  input  logic                 rst,
  parameterized_ror_if.slave   bus
);

  if (N < 2) begin : g_bad_n
    $error("parameterized_ror: N must be >= 2");
  end
  if (M < 0) begin : g_bad_m
    $error("parameterized_ror: M must be >= 0");
  end

  localparam int K = ror_mod((M < 0) ? 0 : M, (N < 2) ? 2 : N);

  logic [N-1:0] rot;
  logic [N-1:0] res_q;
  logic         vld_q;

  ror_core #(
    .N (N),
    .K (K)
  ) u_core (
    .i0  (bus.i0),
    .rot (rot)
  );

  // Reset wins over a simultaneous valid; result holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        res_q <= rot;
      end
    end
  end

  assign bus.result    = res_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_parameterized_ror.sv
// Self-checking bench for parameterized_ror: vector table,
// hand sequences and a random sweep over four parameter sets.
module tb_parameterized_ror;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic [15:0] w16;
  logic [7:0]  w8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  parameterized_ror_if #(.N(16)) b0 ();
  parameterized_ror_if #(.N(16)) b1 ();
  parameterized_ror_if #(.N(16)) b2 ();
  parameterized_ror_if #(.N(8))  b3 ();

  assign b0.in_valid = iv;
  assign b1.in_valid = iv;
  assign b2.in_valid = iv;
  assign b3.in_valid = iv;
  assign b0.i0 = w16;
  assign b1.i0 = w16;
  assign b2.i0 = w16;
  assign b3.i0 = w8;

  parameterized_ror #(.N(16), .M(4))  d0 (.clk(clk), .rst(rst), .bus(b0));
  parameterized_ror #(.N(16), .M(0))  d1 (.clk(clk), .rst(rst), .bus(b1));
  parameterized_ror #(.N(16), .M(20)) d2 (.clk(clk), .rst(rst), .bus(b2));
  parameterized_ror #(.N(8),  .M(1))  d3 (.clk(clk), .rst(rst), .bus(b3));

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [5];

  // Reference: rotate right by m mod n using shift/or arithmetic.
  function automatic logic [63:0] rref(input logic [63:0] x,
                                       input int n, input int m);
    int k;
    logic [63:0] mask;
    k = m % n;
    mask = (64'd1 << n) - 64'd1;
    x = x & mask;
    if (k == 0) return x;
    return ((x >> k) | (x << (n - k))) & mask;
  endfunction

  function automatic int pop(input logic [63:0] x);
    int c = 0;
    for (int i = 0; i < 64; i++) c += int'(x[i]);
    return c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] e0, e1, e2;
  logic [7:0]  e3;
  logic        ev;
  logic [15:0] keep;

  initial begin
    tbl[0] = '{16'b0000000011111111, 16'b1111000000001111};
    tbl[1] = '{16'b1111111100000000, 16'b0000111111110000};
    tbl[2] = '{16'b0011110000001100, 16'b1100001111000000};
    tbl[3] = '{16'b0000101010101010, 16'b1010000010101010};
    tbl[4] = '{16'b1100000000000011, 16'b0011110000000000};

    rst = 1'b1;
    iv  = 1'b1;
    w16 = 16'hFFFF;
    w8  = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_result", b0.result, 16'h0000);
      chk("rst_valid", b0.out_valid, 1'b0);
    end
    rst = 1'b0;
    iv  = 1'b0;
    tick();
    chk("post_rst_result", b0.result, 16'h0000);
    chk("post_rst_valid", b0.out_valid, 1'b0);

    for (int v = 0; v < 5; v++) begin
      iv  = 1'b1;
      w16 = tbl[v].din;
      tick();
      chk($sformatf("vec%0d_result", v), b0.result, tbl[v].exp);
      chk($sformatf("vec%0d_valid", v), b0.out_valid, 1'b1);
      chk($sformatf("vec%0d_pop", v), 64'(pop(b0.result)),
          64'(pop(tbl[v].din)));
    end

    keep = tbl[4].exp;
    iv = 1'b0;
    for (int c = 0; c < 3; c++) begin
      w16 = 16'($urandom);
      tick();
      chk("hold_result", b0.result, keep);
      chk("hold_valid", b0.out_valid, 1'b0);
    end

    rst = 1'b1;
    iv  = 1'b1;
    w16 = 16'h00FF;
    tick();
    chk("rst_vs_valid_result", b0.result, 16'h0000);
    chk("rst_vs_valid_valid", b0.out_valid, 1'b0);
    rst = 1'b0;

    w16 = 16'h1234;
    w8  = 8'b10000001;
    tick();
    chk("first_after_rst", b0.result, 16'h4123);
    chk("first_after_rst_v", b0.out_valid, 1'b1);
    chk("m0_pass", b1.result, 16'h1234);
    chk("m20_eq_m4", b2.result, 16'h4123);
    chk("n8_m1", b3.result, 8'b11000000);

    e0 = b0.result;
    e1 = b1.result;
    e2 = b2.result;
    e3 = b3.result;
    ev = 1'b1;
    if (e0 !== 16'h4123) begin
      e0 = 16'h4123; e1 = 16'h1234; e2 = 16'h4123; e3 = 8'hC0;
    end

    for (int c = 0; c < 1000; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      w16 = 16'($urandom);
      w8  = 8'($urandom);
      tick();
      if (rst) begin
        e0 = '0; e1 = '0; e2 = '0; e3 = '0; ev = 1'b0;
      end else begin
        ev = iv;
        if (iv) begin
          e0 = 16'(rref(64'(w16), 16, 4));
          e1 = 16'(rref(64'(w16), 16, 0));
          e2 = 16'(rref(64'(w16), 16, 20));
          e3 = 8'(rref(64'(w8), 8, 1));
        end
      end
      chk("rnd_m4", b0.result, e0);
      chk("rnd_m0", b1.result, e1);
      chk("rnd_m20", b2.result, e2);
      chk("rnd_n8", b3.result, e3);
      chk("rnd_valid", {b0.out_valid, b1.out_valid,
                        b2.out_valid, b3.out_valid}, {4{ev}});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
